// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
// ------------
// Coprocessor-0 style exception and interrupt controller for a classic
// five-stage pipeline. It holds the Status, Cause and EPC registers,
// arbitrates synchronous exceptions from the MEM stage against enabled
// hardware interrupts, and sequences the one-cycle flush/redirect pulses
// for handler entry and for ERET.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   irq[NUM_IRQ-1:0]         level-sensitive interrupt lines
//   exc_req, exc_code,       MEM-stage exception request, cause code,
//   exc_pc, exc_bd           instruction PC and delay-slot flag
//   eret                     ERET in the MEM stage
//   cp0_we/addr/wdata        MTC0 write port
//   cp0_rdata                MFC0 read data (combinational from cp0_addr)
//   status, cause, epc       live register values
//   flush                    one-cycle pipeline flush pulse
//   redirect, redirect_pc    one-cycle fetch redirect and its target
module cp0_exc_ctrl #(
    parameter int          NUM_IRQ      = 6,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        exc_pc,
    input  logic               exc_bd,
    input  logic               eret,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    output logic [31:0]        cause,
    output logic [31:0]        epc,
    output logic [31:0]        status,
    output logic               flush,
    output logic               redirect,
    output logic [31:0]        redirect_pc
);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_HANDLER,
        S_RETURN
    } state_t;

    state_t             state_q, state_d;
    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic [NUM_IRQ-1:0] ip_q;
    logic               bd_q, bd_d;
    logic [4:0]         code_q, code_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        rpc_q, rpc_d;

    logic               int_take;
    logic               wr_ok;
    logic [31:0]        epc_entry;

    // Only IE, EXL and IM are writable; the remaining data bits are dropped.
    logic unused_wdata_bits;
    assign unused_wdata_bits = ^{cp0_wdata[31:8+NUM_IRQ], cp0_wdata[7:2]};

    assign int_take  = ie_q & ~exl_q & (|(ip_q & im_q));
    // A delay-slot instruction restarts at its branch so the branch re-executes.
    assign epc_entry = exc_bd ? (exc_pc - 32'd4) : exc_pc;

    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        exl_d   = exl_q;
        im_d    = im_q;
        bd_d    = bd_q;
        code_d  = code_q;
        epc_d   = epc_q;
        rpc_d   = rpc_q;
        wr_ok   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Exception wins over interrupt; eret is meaningless here.
                if (exc_req || int_take) begin
                    state_d = S_ENTRY;
                    epc_d   = epc_entry;
                    exl_d   = 1'b1;
                    bd_d    = exc_bd;
                    code_d  = exc_req ? exc_code : 5'd0;
                    rpc_d   = EXC_VECTOR;
                end else begin
                    wr_ok = 1'b1;
                end
            end
            S_ENTRY: begin
                state_d = S_HANDLER;
            end
            S_HANDLER: begin
                // Nested exception keeps the original EPC so ERET returns
                // to the instruction that first trapped.
                if (exc_req) begin
                    state_d = S_ENTRY;
                    bd_d    = exc_bd;
                    code_d  = exc_code;
                    rpc_d   = EXC_VECTOR;
                end else if (eret) begin
                    state_d = S_RETURN;
                    exl_d   = 1'b0;
                    rpc_d   = epc_q;
                end else begin
                    wr_ok = 1'b1;
                end
            end
            S_RETURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // MTC0 only lands when the FSM is not moving this cycle.
        if (wr_ok && cp0_we) begin
            if (cp0_addr == ADDR_STATUS) begin
                ie_d  = cp0_wdata[0];
                exl_d = cp0_wdata[1];
                im_d  = cp0_wdata[8 +: NUM_IRQ];
            end else if (cp0_addr == ADDR_EPC) begin
                epc_d = cp0_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ie_q    <= RESET_STATUS[0];
            exl_q   <= RESET_STATUS[1];
            im_q    <= RESET_STATUS[8 +: NUM_IRQ];
            ip_q    <= '0;
            bd_q    <= 1'b0;
            code_q  <= 5'd0;
            epc_q   <= 32'd0;
            rpc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            im_q    <= im_d;
            ip_q    <= irq;
            bd_q    <= bd_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            rpc_q   <= rpc_d;
        end
    end

    always_comb begin
        status               = 32'd0;
        status[0]            = ie_q;
        status[1]            = exl_q;
        status[8 +: NUM_IRQ] = im_q;
        cause                = 32'd0;
        cause[31]            = bd_q;
        cause[8 +: NUM_IRQ]  = ip_q;
        cause[6:2]           = code_q;
    end

    assign epc = epc_q;

    // Pulses decode straight from the state so reset clears them at once.
    assign flush       = (state_q == S_ENTRY) || (state_q == S_RETURN);
    assign redirect    = flush;
    assign redirect_pc = rpc_q;

    always_comb begin
        case (cp0_addr)
            ADDR_STATUS: cp0_rdata = status;
            ADDR_CAUSE:  cp0_rdata = cause;
            ADDR_EPC:    cp0_rdata = epc_q;
            default:     cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus a randomized
// run, all compared against a behavioural model of the controller.
module tb_cp0_exc_ctrl;

    localparam int          NIRQ = 6;
    localparam logic [31:0] VEC  = 32'h0000_0180;
    localparam logic [31:0] RST_STATUS = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  irq = '0;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic        exc_bd = 1'b0;
    logic        eret = 1'b0;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_addr = 5'd12;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata, cause, epc, status, redirect_pc;
    logic        flush, redirect;

    int errors = 0;
    int checks = 0;

    cp0_exc_ctrl #(.NUM_IRQ(NIRQ), .EXC_VECTOR(VEC), .RESET_STATUS(RST_STATUS)) dut (
        .clk(clk), .rst(rst), .irq(irq), .exc_req(exc_req), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_bd(exc_bd), .eret(eret), .cp0_we(cp0_we),
        .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .cause(cause), .epc(epc), .status(status), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Where the controller is: taking a trap, inside a handler, returning,
    // or running normal code (none of the flags set).
    bit          m_entering, m_in_handler, m_returning;
    bit          m_ie, m_exl, m_bd;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_rpc;

    function automatic logic [31:0] exp_status();
        return {16'h0, m_im, 6'h0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] exp_cause();
        return {m_bd, 15'h0, m_ip, 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        if (a == 5'd12) return exp_status();
        if (a == 5'd13) return exp_cause();
        if (a == 5'd14) return m_epc;
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_entering = 0; m_in_handler = 0; m_returning = 0;
        m_ie = RST_STATUS[0]; m_exl = RST_STATUS[1]; m_im = RST_STATUS[15:8] & 8'h3F;
        m_bd = 0; m_ip = 0; m_code = 0; m_epc = 0; m_rpc = 0;
    endtask

    task automatic model_write();
        if (cp0_we && cp0_addr == 5'd12) begin
            m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1]; m_im = cp0_wdata[15:8] & 8'h3F;
        end else if (cp0_we && cp0_addr == 5'd14) begin
            m_epc = cp0_wdata;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (m_entering) begin
            m_entering = 0; m_in_handler = 1;
        end else if (m_returning) begin
            m_returning = 0;
        end else if (m_in_handler) begin
            if (exc_req) begin
                m_code = exc_code; m_bd = exc_bd;
                m_in_handler = 0; m_entering = 1; m_rpc = VEC;
            end else if (eret) begin
                m_exl = 0; m_in_handler = 0; m_returning = 1; m_rpc = m_epc;
            end else begin
                model_write();
            end
        end else begin
            if (exc_req || (m_ie && !m_exl && ((m_ip & m_im) != 0))) begin
                m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                m_exl = 1; m_bd = exc_bd;
                m_code = exc_req ? exc_code : 5'd0;
                m_entering = 1; m_rpc = VEC;
            end else begin
                model_write();
            end
        end
        m_ip = {2'b00, irq};
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        exc_req = 0; eret = 0; cp0_we = 0; exc_bd = 0;
    endtask

    // Leave a handler through ERET and come back to normal running.
    task automatic leave_handler();
        eret = 1; tick(); eret = 0; tick();
    endtask

    task automatic write_cp0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_addr = a; cp0_wdata = d; tick(); cp0_we = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        @(posedge clk); #1;
        checks++; if (status !== RST_STATUS) begin errors++; $display("FAIL reset_status: got %h want %h", status, RST_STATUS); end
        checks++; if ({cause, epc} !== 64'd0) begin errors++; $display("FAIL reset_cause_epc: got %h/%h want 0/0", cause, epc); end
        checks++; if ({flush, redirect, redirect_pc} !== 34'd0) begin errors++; $display("FAIL reset_pulses: got %b %b %h want 0 0 0", flush, redirect, redirect_pc); end
        checks++; if (cp0_rdata !== RST_STATUS) begin errors++; $display("FAIL reset_rdata: got %h want %h", cp0_rdata, RST_STATUS); end
        rst = 0;
    endtask

    task automatic test_sync_exc();
        exc_req = 1; exc_code = 5'h0C; exc_pc = 32'h0040_0010; exc_bd = 0;
        tick(); quiet();
        checks++; if ({flush, redirect} !== 2'b11) begin errors++; $display("FAIL sync_pulse: got %b%b want 11", flush, redirect); end
        checks++; if (redirect_pc !== 32'h0000_0180) begin errors++; $display("FAIL sync_vector: got %h want 00000180", redirect_pc); end
        checks++; if (epc !== 32'h0040_0010) begin errors++; $display("FAIL sync_epc: got %h want 00400010", epc); end
        checks++; if (cause[6:2] !== 5'h0C) begin errors++; $display("FAIL sync_code: got %h want 0c", cause[6:2]); end
        checks++; if (status[1] !== 1'b1) begin errors++; $display("FAIL sync_exl: got %b want 1", status[1]); end
        tick();
        checks++; if ({flush, redirect} !== 2'b00) begin errors++; $display("FAIL sync_handler_quiet: got %b%b want 00", flush, redirect); end
        eret = 1; tick(); eret = 0;
        checks++; if ({flush, redirect_pc} !== {1'b1, 32'h0040_0010}) begin errors++; $display("FAIL sync_eret: got %b %h want 1 00400010", flush, redirect_pc); end
        tick();
        checks++; if ({flush, status[1]} !== 2'b00) begin errors++; $display("FAIL sync_back_idle: got flush=%b exl=%b want 0 0", flush, status[1]); end
    endtask

    task automatic test_delay_slot();
        exc_req = 1; exc_code = 5'h0C; exc_pc = 32'h0040_0010; exc_bd = 1;
        tick(); quiet();
        checks++; if (epc !== 32'h0040_000C) begin errors++; $display("FAIL bd_epc: got %h want 0040000c", epc); end
        checks++; if (cause[31] !== 1'b1) begin errors++; $display("FAIL bd_flag: got %b want 1", cause[31]); end
        tick(); leave_handler();
    endtask

    task automatic test_irq_mask();
        write_cp0(5'd12, 32'h0000_0101);
        checks++; if ({status, cp0_rdata} !== {2{32'h0000_0101}}) begin errors++; $display("FAIL irq_status_wr: got %h/%h want 00000101", status, cp0_rdata); end
        irq = 6'b000001; tick();
        checks++; if ({flush, cause[8]} !== 2'b01) begin errors++; $display("FAIL irq_ip_latency: got flush=%b ip0=%b want 0 1", flush, cause[8]); end
        tick(); irq = 0;
        checks++; if ({flush, cause[6:2]} !== {1'b1, 5'h00}) begin errors++; $display("FAIL irq_entry: got flush=%b code=%h want 1 00", flush, cause[6:2]); end
        checks++; if (epc !== m_epc) begin errors++; $display("FAIL irq_epc: got %h want %h", epc, m_epc); end
        tick(); leave_handler();
        checks++; if (status !== 32'h0000_0101) begin errors++; $display("FAIL irq_exl_clear: got %h want 00000101", status); end
        write_cp0(5'd12, 32'h0000_0001);
        irq = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL irq_masked_im: got flush=%b want 0", flush); end
        end
        irq = 0; write_cp0(5'd12, 32'h0000_0103); irq = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL irq_masked_exl: got flush=%b want 0", flush); end
        end
        irq = 0; write_cp0(5'd12, 32'h0000_0000); tick();
    endtask

    task automatic test_nested_eret();
        exc_req = 1; exc_code = 5'h0C; exc_pc = 32'h0000_1000; exc_bd = 0;
        tick(); quiet(); tick();
        exc_req = 1; exc_code = 5'h04; exc_pc = 32'h0000_2000; exc_bd = 1;
        tick(); quiet();
        checks++; if (epc !== 32'h0000_1000) begin errors++; $display("FAIL nest_epc: got %h want 00001000", epc); end
        checks++; if ({cause[31], cause[6:2], flush} !== {1'b1, 5'h04, 1'b1}) begin errors++; $display("FAIL nest_cause: got bd=%b code=%h flush=%b want 1 04 1", cause[31], cause[6:2], flush); end
        tick(); eret = 1; tick(); eret = 0;
        checks++; if ({flush, redirect, redirect_pc} !== {2'b11, 32'h0000_1000}) begin errors++; $display("FAIL nest_return: got %b%b %h want 11 00001000", flush, redirect, redirect_pc); end
        tick();
        checks++; if ({flush, status[1]} !== 2'b00) begin errors++; $display("FAIL nest_idle: got flush=%b exl=%b want 0 0", flush, status[1]); end
    endtask

    task automatic test_priority();
        write_cp0(5'd12, 32'h0000_0101);
        exc_req = 1; exc_code = 5'h0D; exc_pc = 32'h0000_3000; exc_bd = 0; irq = 6'b000001;
        cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
        tick(); quiet(); irq = 0;
        checks++; if (epc !== 32'h0000_3000) begin errors++; $display("FAIL prio_epc: got %h want 00003000", epc); end
        checks++; if ({flush, cause[6:2]} !== {1'b1, 5'h0D}) begin errors++; $display("FAIL prio_code: got flush=%b code=%h want 1 0d", flush, cause[6:2]); end
        tick(); leave_handler();
        eret = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({flush, redirect} !== 2'b00) begin errors++; $display("FAIL prio_eret_idle: got %b%b want 00", flush, redirect); end
        end
        eret = 0;
        write_cp0(5'd13, 32'hFFFF_FFFF);
        checks++; if (cause !== exp_cause()) begin errors++; $display("FAIL cause_readonly: got %h want %h", cause, exp_cause()); end
        write_cp0(5'd14, 32'h55AA_0000);
        checks++; if ({epc, cp0_rdata} !== {2{32'h55AA_0000}}) begin errors++; $display("FAIL epc_write: got %h/%h want 55aa0000", epc, cp0_rdata); end
        write_cp0(5'd12, 32'h0000_0000);
    endtask

    task automatic test_reset_mid_entry();
        exc_req = 1; exc_code = 5'h0C; exc_pc = 32'h0000_4000; exc_bd = 0;
        tick(); quiet();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rst_pre_entry: got flush=%b want 1", flush); end
        rst = 1; #1;
        checks++; if ({flush, redirect, redirect_pc} !== 34'd0) begin errors++; $display("FAIL rst_mid_pulses: got %b%b %h want 00 0", flush, redirect, redirect_pc); end
        checks++; if ({status, cause, epc} !== {RST_STATUS, 64'd0}) begin errors++; $display("FAIL rst_mid_regs: got %h %h %h want %h 0 0", status, cause, epc, RST_STATUS); end
        @(posedge clk); #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_held: got flush=%b want 0", flush); end
        rst = 0; model_reset();
        exc_req = 1; exc_pc = 32'h0000_5000;
        tick(); quiet();
        checks++; if ({flush, epc} !== {1'b1, 32'h0000_5000}) begin errors++; $display("FAIL rst_first_edge: got %b %h want 1 00005000", flush, epc); end
        tick(); leave_handler();
    endtask

    task automatic test_random();
        logic [4:0] addrs [4];
        addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd0;
        for (int i = 0; i < 600; i++) begin
            exc_req   = ($urandom_range(0, 7) == 0);
            exc_code  = 5'($urandom);
            exc_pc    = {$urandom} & 32'hFFFF_FFFC;
            exc_bd    = 1'($urandom);
            eret      = ($urandom_range(0, 3) == 0);
            cp0_we    = ($urandom_range(0, 3) == 0);
            cp0_addr  = addrs[$urandom_range(0, 3)];
            if ($urandom_range(0, 4) == 0) cp0_addr = 5'($urandom);
            cp0_wdata = $urandom;
            if ($urandom_range(0, 5) == 0) irq = 6'($urandom);
            tick();
            checks++;
            if ({status, cause, epc, flush, redirect, redirect_pc, cp0_rdata} !==
                {exp_status(), exp_cause(), m_epc, m_entering | m_returning,
                 m_entering | m_returning, m_rpc, exp_rdata(cp0_addr)}) begin
                errors++;
                $display("FAIL random[%0d]: got st=%h ca=%h epc=%h fl=%b rd=%b rpc=%h rdata=%h want st=%h ca=%h epc=%h fl=%b rpc=%h rdata=%h",
                         i, status, cause, epc, flush, redirect, redirect_pc, cp0_rdata,
                         exp_status(), exp_cause(), m_epc, m_entering | m_returning, m_rpc, exp_rdata(cp0_addr));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_exc();
        test_delay_slot();
        test_irq_mask();
        test_nested_eret();
        test_priority();
        test_reset_mid_entry();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 6, number of hardware interrupt lines (legal range 1..8).
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_0180, exception handler entry address.
REQ-003 SHALL have parameter RESET_STATUS, default 32'h0000_0000, Status register value after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port irq  input  NUM_IRQ  level-sensitive interrupt lines.
REQ-007 SHALL have port exc_req  input  1  synchronous exception from the MEM stage.
REQ-008 SHALL have port exc_code  input  5  cause code for exc_req.
REQ-009 SHALL have port exc_pc  input  32  PC of the MEM-stage instruction.
REQ-010 SHALL have port exc_bd  input  1  MEM-stage instruction is in a delay slot.
REQ-011 SHALL have port eret  input  1  ERET in the MEM stage.
REQ-012 SHALL have ports cp0_we (input, 1), cp0_addr (input, 5) and cp0_wdata (input, 32), forming the MTC0 write port.
REQ-013 SHALL have port cp0_rdata  output  32  MFC0 read data, combinational from cp0_addr.
REQ-014 SHALL have ports cause, epc and status, each output, 32 bits, carrying the live register values.
REQ-015 SHALL have port flush  output  1  one-cycle pipeline flush pulse.
REQ-016 SHALL have ports redirect (output, 1) and redirect_pc (output, 32), a one-cycle fetch redirect and its target.

Function
REQ-017 Status bit layout SHALL be: bit0 = IE, bit1 = EXL, bits [8+NUM_IRQ-1:8] = IM; all other bits read 0.
REQ-018 Cause bit layout SHALL be: bit31 = BD, bits [8+NUM_IRQ-1:8] = IP, bits [6:2] = ExcCode; all other bits read 0.
REQ-019 Cause.IP SHALL register irq every cycle in every state, giving 1-cycle latency from irq to IP.
REQ-020 int_take SHALL be IE & ~EXL & |(IP & IM), evaluated only in state IDLE.
REQ-021 The FSM SHALL have four states: IDLE, ENTRY, HANDLER and RETURN.
REQ-022 IDLE SHALL go to ENTRY on exc_req or int_take, and SHALL otherwise stay in IDLE.
REQ-023 On the IDLE-to-ENTRY transition, the block SHALL capture EPC = exc_bd ? exc_pc-4 : exc_pc, set EXL=1 and BD=exc_bd, and set ExcCode = exc_code for an exception or 0 for an interrupt.
REQ-024 When exc_req and int_take are both active in the same cycle, exc_req SHALL win.
REQ-025 ENTRY SHALL last exactly one cycle, drive flush=1, redirect=1 and redirect_pc=EXC_VECTOR, and then go to HANDLER.
REQ-026 In HANDLER, exc_req SHALL update ExcCode and BD, SHALL leave EPC unchanged, and SHALL go to ENTRY (nested exception).
REQ-027 In HANDLER, eret SHALL clear EXL and go to RETURN; when exc_req and eret are both active, exc_req SHALL win.
REQ-028 RETURN SHALL last exactly one cycle, drive flush=1, redirect=1 and redirect_pc=EPC, and then go to IDLE.
REQ-029 In ENTRY and RETURN, exc_req, eret and cp0_we SHALL be ignored, because the pipeline is being flushed.
REQ-030 eret in IDLE SHALL be ignored: no redirect and no state change.
REQ-031 cp0_we with cp0_addr=12 SHALL write only IE, EXL and IM.
REQ-032 cp0_we with cp0_addr=14 SHALL write EPC in full.
REQ-033 Writes to any other cp0_addr, including 13, SHALL be ignored.
REQ-034 When cp0_we coincides with an FSM transition caused by exc_req, int_take or eret, the write SHALL be dropped.
REQ-035 cp0_rdata SHALL return Status, Cause or EPC for cp0_addr 12, 13 or 14 respectively, and 0 for any other address.
REQ-036 flush and redirect SHALL be 0 in IDLE and HANDLER.
REQ-037 redirect_pc SHALL hold its last value outside ENTRY and RETURN.

Reset
REQ-038 While rst=1, the block SHALL immediately force: state=IDLE, status=RESET_STATUS, cause=0, epc=0, flush=0, redirect=0, redirect_pc=0.
REQ-039 Assertion of rst in any state, including ENTRY and RETURN, SHALL abort the operation in progress, with no pulse completing.
REQ-040 The first edge after rst deasserts SHALL be able to sample requests.

Verification
REQ-041 Sync exception: IDLE, exc_req=1, exc_code=5'h0C, exc_pc=32'h0040_0010, exc_bd=0 -> next cycle flush=1, redirect_pc=32'h0000_0180, epc=32'h0040_0010, cause[6:2]=5'h0C, status[1]=1.
REQ-042 Delay slot: as REQ-041 with exc_bd=1 -> epc=32'h0040_000C, cause[31]=1.
REQ-043 Interrupt masking: status=32'h0000_0101, irq[0]=1 -> entry 2 cycles later with ExcCode=0; with IM=0 or EXL=1 -> no entry.
REQ-044 Nested exception then ERET: exception in HANDLER -> EPC unchanged; eret -> one-cycle flush with redirect_pc=original EPC, then IDLE with EXL=0.
REQ-045 Priorities: exc_req, irq and cp0_we (addr 14) in the same cycle -> exception taken, epc=exc_pc (not wdata); eret in IDLE -> no redirect.
REQ-046 Reset mid-ENTRY: assert rst during the flush cycle -> outputs are the reset values within the same cycle, status=RESET_STATUS.
